// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline stage register.
//   DATA_W_DEF / CTRL_W_DEF : default payload widths
//   WREGEN..JALR            : bit positions of the control flags in a ctrl word
//   occ_state_e             : skid-buffer fill state (encoding equals the occupancy count)
package pipe_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CTRL_W_DEF = 16;

    // Control word bit indices.
    localparam int WREGEN  = 0;
    localparam int WMEMEN  = 1;
    localparam int RMEMEN  = 2;
    localparam int MEM2REG = 3;
    localparam int IMM     = 4;
    localparam int LOAD    = 5;
    localparam int STORE   = 6;
    localparam int JAL     = 7;
    localparam int JALR    = 8;

    // Encoded so the state value can be driven straight onto the occupancy port.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot -- one beat of storage: valid flag, control word and data word.
//   CLK, RST_N      : clock, asynchronous active-low reset
//   load            : capture d_ctrl/d_data and set valid (wins over clear)
//   clear           : drop the beat; ctrl is zeroed so an empty slot reads as a NOP,
//                     data keeps its last value
//   d_ctrl, d_data  : payload to capture
//   valid, ctrl, data : registered slot contents
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: the data word is reset too, so the stage powers up presenting a
    // defined all-zero payload rather than X.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, independent of statement order.
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline register between two pipeline stages.
//   SKID=1 : main slot plus skid slot, in_ready registered (breaks the ready path)
//   SKID=0 : single slot, in_ready combinational from out_ready
// Ports:
//   CLK, RST_N                     : clock, asynchronous active-low reset
//   in_valid, in_ready             : upstream handshake
//   in_ctrl, in_data               : upstream payload
//   flush                          : kill every held beat and the beat on the input
//   out_valid, out_ready           : downstream handshake
//   out_ctrl, out_data             : presented payload (ctrl is zero in bubbles)
//   occupancy                      : number of beats held (0..2)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Main slot: the beat presented downstream.
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              m_load;
    logic              m_clear;
    logic [CTRL_W-1:0] m_d_ctrl;
    logic [DATA_W-1:0] m_d_data;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .load   (m_load),
        .clear  (m_clear),
        .d_ctrl (m_d_ctrl),
        .d_data (m_d_data),
        .valid  (m_valid),
        .ctrl   (m_ctrl),
        .data   (m_data)
    );

    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;

    generate
        if (SKID != 0) begin : g_skid
            logic              s_valid;
            logic [CTRL_W-1:0] s_ctrl;
            logic [DATA_W-1:0] s_data;
            logic              s_load;
            logic              s_clear;
            logic              ready_q;
            logic              accept;
            logic              drain;
            occ_state_e        state;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .CLK    (CLK),
                .RST_N  (RST_N),
                .load   (s_load),
                .clear  (s_clear),
                .d_ctrl (in_ctrl),
                .d_data (in_data),
                .valid  (s_valid),
                .ctrl   (s_ctrl),
                .data   (s_data)
            );

            // A beat offered during flush is discarded even when ready is high.
            assign accept = in_valid & ready_q & ~flush;
            assign drain  = m_valid & out_ready;

            always_comb begin
                // NOTE: every output gets a default first so no path leaves a
                // latch behind.
                m_load   = 1'b0;
                m_clear  = 1'b0;
                s_load   = 1'b0;
                s_clear  = 1'b0;
                m_d_ctrl = in_ctrl;
                m_d_data = in_data;
                if (flush) begin
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                end else if (drain) begin
                    if (s_valid) begin
                        // Skid beat is older than anything on the input: promote it.
                        // No accept is possible here since ready_q is low while skid is full.
                        m_load   = 1'b1;
                        m_d_ctrl = s_ctrl;
                        m_d_data = s_data;
                        s_clear  = 1'b1;
                    end else if (accept) begin
                        m_load = 1'b1;
                    end else begin
                        m_clear = 1'b1;
                    end
                end else if (accept) begin
                    if (m_valid) begin
                        s_load = 1'b1;
                    end else begin
                        m_load = 1'b1;
                    end
                end
            end

            // Fill-state FSM; ready_q is the registered "skid slot will be free".
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state   <= ST_EMPTY;
                    ready_q <= 1'b0;
                end else if (flush) begin
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            ready_q <= 1'b1;
                            if (accept) state <= ST_ONE;
                        end
                        ST_ONE: begin
                            if (accept && !drain) begin
                                state   <= ST_FULL;
                                ready_q <= 1'b0;
                            end else if (!accept && drain) begin
                                state   <= ST_EMPTY;
                                ready_q <= 1'b1;
                            end else begin
                                ready_q <= 1'b1;
                            end
                        end
                        ST_FULL: begin
                            if (drain) begin
                                state   <= ST_ONE;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= ST_EMPTY;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end

            assign in_ready  = ready_q;
            assign occupancy = state;
        end else begin : g_single
            logic accept;

            // Gated by RST_N so the stage never advertises ready while held in reset.
            assign in_ready = RST_N & (out_ready | ~m_valid);
            assign accept   = in_valid & in_ready & ~flush;

            always_comb begin
                m_d_ctrl = in_ctrl;
                m_d_data = in_data;
                m_load   = accept;
                m_clear  = flush | (m_valid & out_ready);
            end

            assign occupancy = {1'b0, m_valid};
        end
    endgenerate

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the width of the operand/data payload.
REQ-002 The block SHALL have parameter CTRL_W, default 16, giving the width of the control payload (write enables, mem read/write, imm, load/store, jal/jalr flags).
REQ-003 The block SHALL have parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Interface
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  upstream holds a valid beat.
REQ-007 in_ready  out  1  stage accepts a beat this cycle.
REQ-008 in_ctrl  in  CTRL_W  upstream control bits.
REQ-009 in_data  in  DATA_W  upstream data (R1, R2, sign-ext, func fields, packed).
REQ-010 flush  in  1  kill all held beats (branch/jump redirect).
REQ-011 out_valid  out  1  stage presents a valid beat.
REQ-012 out_ready  in  1  downstream accepts this cycle.
REQ-013 out_ctrl  out  CTRL_W  control of presented beat.
REQ-014 out_data  out  DATA_W  data of presented beat.
REQ-015 occupancy  out  2  beats held (0..2; max 1 when SKID=0).

Function
REQ-016 A beat SHALL transfer in when in_valid && in_ready at a rising edge, and out when out_valid && out_ready.
REQ-017 Latency in->out SHALL be exactly 1 cycle when the stage is empty; sustained throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-018 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble = NOP); out_data SHALL hold its last value when out_valid=0.
REQ-019 SKID=1: in_ready SHALL equal registered !skid_full, independent of out_ready in the same cycle.
REQ-020 SKID=1: beat accepted while main slot full and not leaving SHALL go to the skid slot; when main slot drains, the skid beat SHALL move to main the same edge (FIFO order preserved).
REQ-021 SKID=1 states: EMPTY (occ 0), ONE (occ 1), FULL (occ 2); EMPTY->ONE on accept; ONE->FULL on accept without drain; ONE->EMPTY on drain without accept; ONE stays on accept+drain; FULL->ONE on drain (no accept possible); any->EMPTY on flush.
REQ-022 SKID=0: in_ready SHALL equal out_ready || !out_valid, combinationally.
REQ-023 Payload SHALL not change while out_valid=1 && out_ready=0.
REQ-024 flush SHALL have priority: at the edge, all slots become invalid, out_ctrl zero, occupancy 0; a beat offered in the flush cycle SHALL be discarded even if in_ready=1.
REQ-025 in_ready SHALL be 1 in the cycle after flush.

Reset
REQ-026 On RST_N=0, asynchronously: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid slot invalid/zero.
REQ-027 in_ready SHALL be 0 while RST_N=0 and 1 in the first cycle after release; reset mid-transfer SHALL drop all held beats.

Structure
REQ-028 Package pipe_pkg SHALL hold default DATA_W/CTRL_W and the ctrl bit-index constants (WREGEN, WMEMEN, RMEMEN, MEM2REG, IMM, LOAD, STORE, JAL, JALR).
REQ-029 A sub-module pipe_slot (one valid+ctrl+data register with load/clear) SHALL be instantiated twice for SKID=1, once for SKID=0.

Verification
REQ-030 Reset: RST_N=0 mid-stream with occ=2 -> out_valid=0, out_ctrl=0, occupancy=0 immediately; in_ready=1 first cycle after release.
REQ-031 Streaming: 8 beats data=1..8, out_ready=1 -> out data 1..8 on consecutive cycles, first 1 cycle after first accept.
REQ-032 Backpressure SKID=1: out_ready=0, send A,B,C -> A,B accepted, occupancy=2, in_ready=0, C held upstream; out_ready=1 -> A,B,C out in order, no loss/duplication.
REQ-033 Flush: occ=2, flush=1 with in_valid=1 data=0xDEAD -> next cycle out_valid=0, out_ctrl=0, occupancy=0, 0xDEAD never appears.
REQ-034 SKID=0: out_ready toggling 1,0,1 with continuous input -> in_ready mirrors out_ready same cycle, output order preserved.
REQ-035 Random valid/ready for 10k cycles, both SKID values -> scoreboard matches, out_ctrl=0 whenever out_valid=0.
